weight_loader: RTL and testbench

- Upstream feeder for the convolver weight register.
- Accepts kernel weights one DATA_WIDTH word per beat over a valid/ready stream.
- Assembles N words into a packed N*DATA_WIDTH vector.
- Issues a single-cycle write strobe so the weight register captures the complete set atomically. A partially loaded kernel never reaches the register.

---
 rtl/weight_loader_pkg.sv | 18 +
 rtl/weight_loader.sv | 108 ++++++++++
 tb/tb_weight_loader.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/weight_loader_pkg.sv
// Shared definitions for the weight_loader block.
//   state_t     : loader FSM states (FILL, COMMIT)
//   SETS_W      : width of the committed-set counter
//   count_width : width needed to count 0..n inclusive
package weight_loader_pkg;

    typedef enum logic {
        FILL   = 1'b0,
        COMMIT = 1'b1
    } state_t;

    localparam int SETS_W = 16;

    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/weight_loader.sv
// weight_loader: upstream feeder for the convolver weight register.
// Collects N words of DATA_WIDTH from a valid/ready stream into a packed
// staging vector, then raises a one-cycle write strobe so the weight
// register captures the whole kernel set at once.
//
// Ports:
//   clock, reset      rising-edge clock, async active-high reset
//   in_valid/in_ready word stream handshake, in_data carries the word
//   abort             synchronous discard of the partially assembled set
//   weight_write      packed set, slot k at [k*DATA_WIDTH +: DATA_WIDTH]
//   write             one-cycle commit strobe
//   fill_count        words accepted in the current set
//   sets_loaded       committed sets, wraps at 2^16
//   checksum          (only with WEIGHT_LOADER_CHECKSUM_EN) mod-2^DATA_WIDTH
//                     sum of the words in the current set, valid while write=1
//
// Optional feature macro: WEIGHT_LOADER_CHECKSUM_EN
//
// state  | meaning
// FILL   | accepting words into staging, in_ready high
// COMMIT | one cycle, write high, staging holds the complete set
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int N          = 25,
    localparam int CNT_W      = count_width(N)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    abort,
    output logic [N*DATA_WIDTH-1:0] weight_write,
    output logic                    write,
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0]   checksum,
`endif
    output logic [CNT_W-1:0]        fill_count,
    output logic [SETS_W-1:0]       sets_loaded
);

    state_t state, state_next;
    logic   ready_en;
    logic   take;

    // Holds in_ready low until the first edge after reset is released.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) ready_en <= 1'b0;
        else       ready_en <= 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= FILL;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        write      = 1'b0;
        case (state)
            FILL: begin
                in_ready = ready_en;
                // abort beats the final accept, so no commit happens then
                if (ready_en && in_valid && !abort && fill_count == CNT_W'(N - 1))
                    state_next = COMMIT;
            end
            COMMIT: begin
                write      = 1'b1;
                state_next = FILL;
            end
            default: state_next = FILL;
        endcase
    end

    assign take = (state == FILL) && ready_en && in_valid && !abort;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fill_count   <= '0;
            sets_loaded  <= '0;
            weight_write <= '0;
        end else if (state == COMMIT) begin
            fill_count  <= '0;
            sets_loaded <= sets_loaded + 1'b1;
        end else if (abort) begin
            // staging is kept; only the fill pointer is rewound
            fill_count <= '0;
        end else if (take) begin
            fill_count <= fill_count + 1'b1;
            for (int k = 0; k < N; k++) begin
                if (fill_count == CNT_W'(k))
                    weight_write[k*DATA_WIDTH +: DATA_WIDTH] <= in_data;
            end
        end
    end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                        checksum <= '0;
        else if (state == COMMIT || abort) checksum <= '0;
        else if (take)                    checksum <= checksum + in_data;
    end
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader with N=4, DATA_WIDTH=16.
module tb_weight_loader;
    import weight_loader_pkg::*;

    localparam int DW = 16;
    localparam int NW = 4;
    localparam int CW = count_width(NW);

    logic              clock = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     in_data;
    logic              abort;
    logic [NW*DW-1:0]  weight_write;
    logic              write;
    logic [CW-1:0]     fill_count;
    logic [SETS_W-1:0] sets_loaded;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    logic [DW-1:0]     checksum;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    weight_loader #(.DATA_WIDTH(DW), .N(NW)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .abort        (abort),
        .weight_write (weight_write),
        .write        (write),
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        .checksum     (checksum),
`endif
        .fill_count   (fill_count),
        .sets_loaded  (sets_loaded)
    );

    always #5 clock = ~clock;

    // write is a full-cycle level, so each pulse is seen by exactly one negedge
    always @(negedge clock) if (write === 1'b1) pulses++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one word and hold it until accepted (bounded wait).
    task automatic load(input logic [DW-1:0] w);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = w;
        while (in_ready !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        if (in_ready !== 1'b1) check("ready_timeout", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        abort    = 1'b0;
        tick();
        tick();
        check("rst_ready",  64'(in_ready),     64'd0);
        check("rst_fill",   64'(fill_count),   64'd0);
        check("rst_write",  64'(write),        64'd0);
        check("rst_sets",   64'(sets_loaded),  64'd0);
        check("rst_stage",  weight_write,      64'd0);
        reset = 1'b0;
        tick();
        check("ready_after_rst", 64'(in_ready), 64'd1);

        // continuous stream
        for (int i = 0; i < NW; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i + 1);
            tick();
            check("cont_fill", 64'(fill_count), 64'(i + 1));
        end
        in_valid = 1'b0;
        check("cont_write", 64'(write),    64'd1);
        check("cont_ready", 64'(in_ready), 64'd0);
        check("cont_data",  weight_write,  64'h0004_0003_0002_0001);
        tick();
        check("cont_write_end", 64'(write),       64'd0);
        check("cont_sets",      64'(sets_loaded), 64'd1);
        check("cont_fill_clr",  64'(fill_count),  64'd0);
        check("cont_pulses",    64'(pulses),      64'd1);

        // in_valid toggled every other cycle
        for (int i = 0; i < NW; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(i + 1);
            tick();
            in_valid = 1'b0;
            check("tog_fill", 64'(fill_count), 64'(i + 1));
            if (i < NW - 1) begin
                check("tog_nowrite", 64'(write), 64'd0);
                tick();
                check("tog_hold", 64'(fill_count), 64'(i + 1));
            end
        end
        check("tog_write", 64'(write),   64'd1);
        check("tog_data",  weight_write, 64'h0004_0003_0002_0001);
        tick();
        check("tog_sets",   64'(sets_loaded), 64'd2);
        check("tog_pulses", 64'(pulses),      64'd2);

        // abort after two words, then a full set
        load(16'h0011);
        load(16'h0022);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_fill",  64'(fill_count), 64'd0);
        check("abort_write", 64'(write),      64'd0);
        load(16'h000A);
        load(16'h000B);
        load(16'h000C);
        load(16'h000D);
        check("abort_data", weight_write, 64'h000D_000C_000B_000A);
        tick();
        check("abort_sets",   64'(sets_loaded), 64'd3);
        check("abort_pulses", 64'(pulses),      64'd3);

        // abort coinciding with the final accept
        load(16'h0005);
        load(16'h0006);
        load(16'h0007);
        in_valid = 1'b1;
        in_data  = 16'h0008;
        abort    = 1'b1;
        tick();
        in_valid = 1'b0;
        abort    = 1'b0;
        check("abort4_write", 64'(write),      64'd0);
        check("abort4_fill",  64'(fill_count), 64'd0);
        tick();
        check("abort4_write2", 64'(write), 64'd0);
        load(16'h0021);
        load(16'h0022);
        load(16'h0023);
        load(16'h0024);
        check("abort4_commit", 64'(write),   64'd1);
        check("abort4_data",   weight_write, 64'h0024_0023_0022_0021);
        tick();
        check("abort4_sets", 64'(sets_loaded), 64'd4);

        // reset in the middle of a set
        load(16'h0031);
        load(16'h0032);
        load(16'h0033);
        reset = 1'b1;
        #1;
        check("mid_rst_fill",  64'(fill_count),  64'd0);
        check("mid_rst_stage", weight_write,     64'd0);
        check("mid_rst_sets",  64'(sets_loaded), 64'd0);
        check("mid_rst_ready", 64'(in_ready),    64'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("mid_rst_pulses", 64'(pulses), 64'd4);
        load(16'h0041);
        load(16'h0042);
        load(16'h0043);
        check("mid_rst_partial", 64'(write), 64'd0);
        load(16'h0044);
        check("mid_rst_commit", 64'(write),   64'd1);
        check("mid_rst_data",   weight_write, 64'h0044_0043_0042_0041);
        tick();
        check("mid_rst_sets2",  64'(sets_loaded), 64'd1);
        check("mid_rst_pulses2", 64'(pulses),     64'd5);

`ifdef WEIGHT_LOADER_CHECKSUM_EN
        load(16'hFFFF);
        load(16'h0002);
        load(16'h0000);
        load(16'h0001);
        check("csum_write", 64'(write),    64'd1);
        check("csum_value", 64'(checksum), 64'h0002);
        tick();
        check("csum_clear", 64'(checksum), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
